// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  // Prefix bytes sent by the keyboard ahead of the key code.
  localparam logic [7:0] E0 = 8'hE0;
  localparam logic [7:0] E1 = 8'hE1;
  localparam logic [7:0] F0 = 8'hF0;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BYTE
  } ps2_fsm_t;

  typedef struct packed {
    logic       toggle;
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

  // Keyboard replies and status codes that carry no key meaning on their own.
  function automatic logic is_non_key(input logic [7:0] c);
    case (c)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_non_key = 1'b1;
      default:                                                  is_non_key = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronisers on clock and data, a
// saturating-count glitch filter on the clock, and a falling-edge strobe.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic strobe_o,
  output logic data_o
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic             clk_meta_q, clk_sync_q;
  logic             dat_meta_q, dat_sync_q;
  logic             filt_q, filt_prev_q;
  logic [CNT_W-1:0] cnt_q;

  // Bring both asynchronous lines into the clk domain; idle level is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data_i;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Filtered clock only follows the line after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_sync_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        filt_q <= clk_sync_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign strobe_o = filt_prev_q & ~filt_q;
  assign data_o   = dat_sync_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver producing the 11-bit toggle-format key event word
// {toggle, pressed, extended, code}. Optional build macro
// PS2_REPEAT_FILTER_EN adds a pressed-key table that suppresses typematic
// repeats of make codes.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter real CLK_FREQ   = 96.0,
  parameter int  TIMEOUT_US = 200,
  parameter int  FILTER_LEN = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err,
  output ps2_fsm_t    dbg_state
);

  localparam int WDOG_RAW  = int'(CLK_FREQ * real'(TIMEOUT_US));
  localparam int WDOG_LOAD = (WDOG_RAW < 1) ? 1 : WDOG_RAW;
  localparam int WDOG_W    = $clog2(WDOG_LOAD + 1);
  localparam logic [WDOG_W-1:0] WDOG_INIT = WDOG_W'(WDOG_LOAD);

  logic strobe;
  logic sdata;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .strobe_o  (strobe),
    .data_o    (sdata)
  );

  ps2_fsm_t          state_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              par_q;
  logic              ext_q;
  logic              rel_q;
  logic [2:0]        skip_q;
  logic [WDOG_W-1:0] wdog_q;
  ps2_event_t        key_q;
  logic              key_strobe_q;
  logic              frame_err_q;
  logic              timeout;

`ifdef PS2_REPEAT_FILTER_EN
  logic [511:0] pressed_tbl_q;
  logic [8:0]   tbl_idx;
  assign tbl_idx = {ext_q, shift_q};
`endif

  // Inter-edge gap exceeded while a frame is in progress.
  assign timeout = (state_q != IDLE) && !strobe && (wdog_q == '0);

  // Watchdog reloads on every sample strobe and counts down towards zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else if (strobe) begin
      wdog_q <= WDOG_INIT;
    end else if (wdog_q != '0) begin
      wdog_q <= wdog_q - 1'b1;
    end
  end

  // Frame FSM, prefix tracking and event generation with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      skip_q       <= '0;
      key_q        <= '0;
      key_strobe_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
      pressed_tbl_q <= '0;
`endif
    end else begin
      key_strobe_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (timeout) begin
        // Abandon the partial frame and any pending prefixes; skip count survives.
        state_q     <= IDLE;
        bit_cnt_q   <= '0;
        frame_err_q <= 1'b1;
        ext_q       <= 1'b0;
        rel_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (strobe) begin
              if (!sdata) begin
                state_q   <= DATA;
                bit_cnt_q <= '0;
              end else begin
                frame_err_q <= 1'b1;
                ext_q       <= 1'b0;
                rel_q       <= 1'b0;
              end
            end
          end
          DATA: begin
            if (strobe) begin
              shift_q <= {sdata, shift_q[7:1]};
              if (bit_cnt_q == 3'd7) begin
                state_q <= PARITY;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          PARITY: begin
            if (strobe) begin
              par_q   <= sdata;
              state_q <= STOP;
            end
          end
          STOP: begin
            if (strobe) begin
              if (sdata && (^{shift_q, par_q})) begin
                state_q <= BYTE;
              end else begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
                ext_q       <= 1'b0;
                rel_q       <= 1'b0;
              end
            end
          end
          BYTE: begin
            state_q <= IDLE;
            if (skip_q != '0) begin
              skip_q <= skip_q - 3'd1;
            end else if (shift_q == E1) begin
              // Pause sequence: swallow the remaining seven bytes.
              skip_q <= 3'd7;
              ext_q  <= 1'b0;
              rel_q  <= 1'b0;
            end else if (shift_q == E0) begin
              ext_q <= 1'b1;
            end else if (shift_q == F0) begin
              rel_q <= 1'b1;
            end else if (!ext_q && !rel_q && is_non_key(shift_q)) begin
              // Status/reply byte with no prefix: no key event.
            end else begin
              ext_q <= 1'b0;
              rel_q <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
              if (rel_q || !pressed_tbl_q[tbl_idx]) begin
                key_q        <= '{toggle: ~key_q.toggle, pressed: ~rel_q, ext: ext_q, code: shift_q};
                key_strobe_q <= 1'b1;
                pressed_tbl_q[tbl_idx] <= ~rel_q;
              end
`else
              key_q        <= '{toggle: ~key_q.toggle, pressed: ~rel_q, ext: ext_q, code: shift_q};
              key_strobe_q <= 1'b1;
`endif
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ps2_key    = key_q;
  assign key_strobe = key_strobe_q;
  assign frame_err  = frame_err_q;
  assign dbg_state  = state_q;

endmodule
